// File: rtl/ex_cnt_param.sv
// ex_cnt_param: parametrised up/down counter with prescaler, sync clear/load and terminal-count pulse.
// Define EX_CNT_SAT_EN to saturate at 0/MAX_VAL instead of wrapping.
module ex_cnt_param #(
    parameter int WIDTH    = 10,
    parameter int MAX_VAL  = 1023,
    parameter int PRESCALE = 1
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             zero
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_pre, w_pre_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_step, w_bound_val, w_load_val;
    logic             r_tc, w_tc_nxt, w_tick, w_bound, w_hit;

    assign w_tick     = en && (r_pre == PTOP);
    assign w_bound    = up_dn ? (r_cnt == MAX) : (r_cnt == '0);
    assign w_step     = up_dn ? r_cnt + 1'b1 : r_cnt - 1'b1;
    assign w_load_val = (load_val > MAX) ? MAX : load_val;
`ifdef EX_CNT_SAT_EN
    // Saturation: hold at the boundary; pulse only on the step that lands there.
    assign w_bound_val = r_cnt;
    assign w_hit       = !w_bound && (w_step == (up_dn ? MAX : '0));
`else
    assign w_bound_val = up_dn ? '0 : MAX;
    assign w_hit       = w_bound;
`endif

    always_comb begin
        w_pre_nxt = (clr || load || w_tick) ? '0 : en ? r_pre + 1'b1 : r_pre;
        w_cnt_nxt = clr ? '0 : load ? w_load_val : w_tick ? (w_bound ? w_bound_val : w_step) : r_cnt;
        w_tc_nxt  = !clr && !load && w_tick && w_hit;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_pre <= w_pre_nxt;
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_tc_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign tc   = r_tc;
    assign zero = (r_cnt == '0);
endmodule

// File: tb/tb_ex_cnt_param.sv
// tb_ex_cnt_param: directed checks of ex_cnt_param in three configurations (default, 4/9/3, 8/255/1).
// Expectations follow EX_CNT_SAT_EN when it is defined for the build.
module tb_ex_cnt_param;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic       a_en = 0, a_up = 1, a_clr = 0, a_load = 0;
    logic [9:0] a_lv = '0, a_cnt;
    logic       a_tc, a_zero;
    logic       b_en = 0, b_up = 1, b_clr = 0, b_load = 0;
    logic [3:0] b_lv = '0, b_cnt;
    logic       b_tc, b_zero;
    logic       c_en = 0, c_up = 1, c_clr = 0, c_load = 0;
    logic [7:0] c_lv = '0, c_cnt;
    logic       c_tc, c_zero;
    logic       sat;

    always #5 sclk = ~sclk;

    ex_cnt_param dut_a (
        .sclk(sclk), .rst(rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .cnt(a_cnt), .tc(a_tc), .zero(a_zero)
    );
    ex_cnt_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
        .sclk(sclk), .rst(rst), .en(b_en), .up_dn(b_up), .clr(b_clr), .load(b_load),
        .load_val(b_lv), .cnt(b_cnt), .tc(b_tc), .zero(b_zero)
    );
    ex_cnt_param #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1)) dut_c (
        .sclk(sclk), .rst(rst), .en(c_en), .up_dn(c_up), .clr(c_clr), .load(c_load),
        .load_val(c_lv), .cnt(c_cnt), .tc(c_tc), .zero(c_zero)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    initial begin
`ifdef EX_CNT_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        #12;
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_tc", a_tc, 0);
        chk("rst_a_zero", a_zero, 1);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_c_cnt", c_cnt, 0);
        rst = 1'b0;

        // Default config: full up count and wrap
        a_en = 1;
        for (int i = 1; i <= 1023; i++) begin
            tick(1);
            chk("a_up_cnt", a_cnt, i);
            if (i < 1023) chk("a_up_tc", a_tc, 0);
        end
        chk("a_top_tc", a_tc, sat ? 1 : 0);
        chk("a_top_zero", a_zero, 0);
        tick(1);
        chk("a_wrap_cnt", a_cnt, sat ? 1023 : 0);
        chk("a_wrap_tc", a_tc, sat ? 0 : 1);
        chk("a_wrap_zero", a_zero, sat ? 0 : 1);
        tick(1);
        chk("a_after_cnt", a_cnt, sat ? 1023 : 1);
        chk("a_after_tc", a_tc, 0);
        a_en = 0;

        // Prescale 3, down, en gap mid-prescale
        b_load = 1; b_lv = 4'd5;
        tick(1);
        b_load = 0;
        chk("b_ld5_cnt", b_cnt, 5);
        b_up = 0; b_en = 1;
        tick(2); chk("b_pre_hold", b_cnt, 5);
        tick(1); chk("b_step4", b_cnt, 4);
        tick(1);
        b_en = 0;
        tick(2); chk("b_en_gap", b_cnt, 4);
        b_en = 1;
        tick(1); chk("b_resume_hold", b_cnt, 4);
        tick(1); chk("b_step3", b_cnt, 3);
        tick(3); chk("b_step2", b_cnt, 2);
        tick(3); chk("b_step1", b_cnt, 1);
        tick(3);
        chk("b_step0", b_cnt, 0);
        chk("b_step0_tc", b_tc, sat ? 1 : 0);
        chk("b_step0_zero", b_zero, 1);
        tick(3);
        chk("b_dnwrap_cnt", b_cnt, sat ? 0 : 9);
        chk("b_dnwrap_tc", b_tc, sat ? 0 : 1);
        tick(1);
        chk("b_tc_clear", b_tc, 0);
        b_en = 0;

        // Load clamp, load vs tick, clr vs load
        b_load = 1; b_lv = 4'd13;
        tick(1);
        b_load = 0;
        chk("b_ld_clamp", b_cnt, 9);
        b_up = 1; b_en = 1;
        tick(2); chk("b_pre_top", b_cnt, 9);
        b_load = 1; b_lv = 4'd3;
        tick(1);
        b_load = 0;
        chk("b_ld_tick_cnt", b_cnt, 3);
        chk("b_ld_tick_tc", b_tc, 0);
        tick(2); chk("b_ld_pre_hold", b_cnt, 3);
        tick(1); chk("b_ld_pre_step", b_cnt, 4);
        tick(1);
        b_clr = 1; b_load = 1; b_lv = 4'd7;
        tick(1);
        b_clr = 0; b_load = 0;
        chk("b_clr_cnt", b_cnt, 0);
        chk("b_clr_zero", b_zero, 1);
        chk("b_clr_tc", b_tc, 0);
        tick(2); chk("b_clr_pre_hold", b_cnt, 0);
        tick(1); chk("b_clr_pre_step", b_cnt, 1);
        b_en = 0;

        // Async reset between edges
        b_load = 1; b_lv = 4'd5;
        tick(1);
        b_load = 0;
        chk("b_ld5b", b_cnt, 5);
        b_en = 1;
        tick(1);
        #3 rst = 1;
        #1;
        chk("arst_b_cnt", b_cnt, 0);
        chk("arst_b_tc", b_tc, 0);
        chk("arst_b_zero", b_zero, 1);
        chk("arst_a_cnt", a_cnt, 0);
        #2 rst = 0;
        tick(2); chk("arst_pre_hold", b_cnt, 0);
        tick(1); chk("arst_pre_step", b_cnt, 1);

        // Upper boundary, then reverse direction
        b_en = 0;
        b_load = 1; b_lv = 4'd7;
        tick(1);
        b_load = 0;
        b_en = 1;
        tick(3);
        chk("b_up8", b_cnt, 8);
        chk("b_up8_tc", b_tc, 0);
        tick(3);
        chk("b_up9", b_cnt, 9);
        chk("b_up9_tc", b_tc, sat ? 1 : 0);
        tick(1); chk("b_up9_tc_clr", b_tc, 0);
        tick(2);
        chk("b_upnext", b_cnt, sat ? 9 : 0);
        chk("b_upnext_tc", b_tc, sat ? 0 : 1);
        b_up = 0;
        tick(3);
        chk("b_rev", b_cnt, sat ? 8 : 9);
        chk("b_rev_tc", b_tc, sat ? 0 : 1);
        if (sat) begin
            for (int k = 7; k >= 0; k--) begin
                tick(3);
                chk("b_sat_dn", b_cnt, k);
                chk("b_sat_dn_tc", b_tc, k == 0 ? 1 : 0);
            end
            tick(3);
            chk("b_sat_hold0", b_cnt, 0);
            chk("b_sat_hold0_tc", b_tc, 0);
        end
        b_en = 0;
        b_load = 1; b_lv = 4'd9;
        tick(1);
        b_load = 0;
        chk("b_ld_bound_cnt", b_cnt, 9);
        chk("b_ld_bound_tc", b_tc, 0);

        // Width-limit wrap
        c_load = 1; c_lv = 8'd254;
        tick(1);
        c_load = 0;
        c_en = 1;
        tick(1);
        chk("c_255", c_cnt, 255);
        chk("c_255_tc", c_tc, sat ? 1 : 0);
        tick(1);
        chk("c_wrap", c_cnt, sat ? 255 : 0);
        chk("c_wrap_tc", c_tc, sat ? 0 : 1);
        c_en = 0;
        c_load = 1; c_lv = 8'd0;
        tick(1);
        c_load = 0;
        c_up = 0; c_en = 1;
        tick(1);
        chk("c_dnwrap", c_cnt, sat ? 0 : 255);
        chk("c_dnwrap_tc", c_tc, sat ? 0 : 1);
        c_en = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
